// File: rtl/updown_game_core.sv
// updown_game_core: up/down number-guessing game core.
// An LFSR supplies secret candidates that are rejection-sampled into 1..NUM_MAX.
// Guesses are validated, compared and counted against an attempt budget, and the
// round ends in WIN or LOSE. `start` begins or restarts a round from any state.
// Optional feature macro: UPDOWN_HINT_RANGE_EN adds narrowing lo_bound/hi_bound
// hints and rejects guesses outside them.
module updown_game_core #(
  parameter int          NUM_W     = 7,
  parameter int          NUM_MAX   = 99,
  parameter int          MAX_TRIES = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             guess_trigger,
  input  logic [NUM_W-1:0] user_number,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic             guess_reject,
  output logic [TRY_W-1:0] tries_used,
  output logic             busy,
  output logic             game_over,
  output logic             game_won,
  output logic [NUM_W-1:0] actual_number_out
`ifdef UPDOWN_HINT_RANGE_EN
  ,
  output logic [NUM_W-1:0] lo_bound,
  output logic [NUM_W-1:0] hi_bound
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_PLAY,
    S_WIN,
    S_LOSE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [NUM_W-1:0] MAX_N    = NUM_W'(NUM_MAX);
  localparam logic [NUM_W-1:0] ONE_N    = NUM_W'(1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_UP   = 2'b01;
  localparam logic [1:0] RES_DOWN = 2'b10;
  localparam logic [1:0] RES_HIT  = 2'b11;

  state_t           state;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic [NUM_W-1:0] secret;
  logic [NUM_W-1:0] candidate;
  logic             cand_ok;
  logic             guess_ok;
  logic             guess_hit;
  logic             guess_low;
  logic [TRY_W-1:0] tries_next;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign candidate  = lfsr[NUM_W-1:0];
  assign cand_ok    = (candidate != '0) && (candidate <= MAX_N);
  assign guess_hit  = (user_number == secret);
  assign guess_low  = (user_number < secret);
  assign tries_next = tries_used + TRY_ONE;

`ifdef UPDOWN_HINT_RANGE_EN
  assign guess_ok = (user_number != '0) && (user_number <= MAX_N) &&
                    (user_number >= lo_bound) && (user_number <= hi_bound);
`else
  assign guess_ok = (user_number != '0) && (user_number <= MAX_N);
`endif

  assign actual_number_out = secret;

  // Free-running Fibonacci LFSR; it keeps stepping between rounds so each round
  // draws from a different point of the sequence.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Game FSM: round sequencing, guess evaluation and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      secret       <= '0;
      result       <= RES_NONE;
      result_valid <= 1'b0;
      guess_reject <= 1'b0;
      tries_used   <= '0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
`ifdef UPDOWN_HINT_RANGE_EN
      lo_bound     <= ONE_N;
      hi_bound     <= MAX_N;
`endif
    end else begin
      result_valid <= 1'b0;
      guess_reject <= 1'b0;
      if (start) begin
        // start has priority over everything, including a same-cycle guess.
        state      <= S_GEN;
        result     <= RES_NONE;
        tries_used <= '0;
        busy       <= 1'b1;
        game_over  <= 1'b0;
        game_won   <= 1'b0;
`ifdef UPDOWN_HINT_RANGE_EN
        lo_bound   <= ONE_N;
        hi_bound   <= MAX_N;
`endif
      end else begin
        case (state)
          S_GEN: begin
            // Rejection sampling keeps the secret uniform over the legal range.
            if (cand_ok) begin
              secret <= candidate;
              state  <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (guess_trigger) begin
              if (!guess_ok) begin
                guess_reject <= 1'b1;
              end else begin
                result_valid <= 1'b1;
                tries_used   <= tries_next;
                if (guess_hit) begin
                  result    <= RES_HIT;
                  state     <= S_WIN;
                  busy      <= 1'b0;
                  game_over <= 1'b1;
                  game_won  <= 1'b1;
                end else begin
                  result <= guess_low ? RES_UP : RES_DOWN;
`ifdef UPDOWN_HINT_RANGE_EN
                  if (guess_low) lo_bound <= user_number + ONE_N;
                  else           hi_bound <= user_number - ONE_N;
`endif
                  if (tries_next == TRY_LAST) begin
                    state     <= S_LOSE;
                    busy      <= 1'b0;
                    game_over <= 1'b1;
                  end
                end
              end
            end
          end
          default: begin
            // IDLE, WIN and LOSE hold their outputs until start.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_game_core.sv
// Self-checking bench for updown_game_core: default-parameter instance plus a
// MAX_TRIES=3 instance, a reference LFSR model predicting each secret, and
// per-instance scoreboards of expected result/valid/reject pulses.
module tb_updown_game_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0, guess_trigger = 1'b0;
  logic [6:0] user_number = '0;
  logic [1:0] result;
  logic       result_valid, guess_reject, busy, game_over, game_won;
  logic [2:0] tries_used;
  logic [6:0] actual;

  logic       start3 = 1'b0, trig3 = 1'b0;
  logic [6:0] num3 = '0;
  logic [1:0] result3;
  logic       rv3, rej3, busy3, over3, won3;
  logic [1:0] tries3;
  logic [6:0] act3;
`ifdef UPDOWN_HINT_RANGE_EN
  logic [6:0] lo_b, hi_b, lo3, hi3;
`endif

  updown_game_core dut (
    .clk(clk), .reset(reset), .start(start), .guess_trigger(guess_trigger),
    .user_number(user_number), .result(result), .result_valid(result_valid),
    .guess_reject(guess_reject), .tries_used(tries_used), .busy(busy),
    .game_over(game_over), .game_won(game_won), .actual_number_out(actual)
`ifdef UPDOWN_HINT_RANGE_EN
    , .lo_bound(lo_b), .hi_bound(hi_b)
`endif
  );

  updown_game_core #(.MAX_TRIES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .guess_trigger(trig3),
    .user_number(num3), .result(result3), .result_valid(rv3),
    .guess_reject(rej3), .tries_used(tries3), .busy(busy3),
    .game_over(over3), .game_won(won3), .actual_number_out(act3)
`ifdef UPDOWN_HINT_RANGE_EN
    , .lo_bound(lo3), .hi_bound(hi3)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] first_secret;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, left shift, seed 0xACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct packed {
    logic [1:0] res;
    logic       vld;
    logic       rej;
  } exp_t;
  exp_t q0[$];
  exp_t q3[$];

  function automatic exp_t mk(input logic [1:0] res, input logic vld, input logic rej);
    exp_t e;
    e.res = res; e.vld = vld; e.rej = rej;
    return e;
  endfunction

  // Expected code: 01 when secret > guess, 10 when secret < guess, 11 on a hit.
  function automatic logic [1:0] cmp(input logic [6:0] s, input logic [6:0] g);
    if (g < s)      return 2'b01;
    else if (g > s) return 2'b10;
    else            return 2'b11;
  endfunction

  // Scoreboard monitors: one entry is due on each edge after a trigger is driven.
  always @(posedge clk) begin
    exp_t e0, e3;
    #1;
    checks++;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      if ({result, result_valid, guess_reject} !== {e0.res, e0.vld, e0.rej}) begin
        errors++;
        $display("FAIL sb_main: got res=%b vld=%b rej=%b, want res=%b vld=%b rej=%b",
                 result, result_valid, guess_reject, e0.res, e0.vld, e0.rej);
      end
    end else if (result_valid !== 1'b0 || guess_reject !== 1'b0) begin
      errors++;
      $display("FAIL sb_main_idle: got vld=%b rej=%b, want 0 0", result_valid, guess_reject);
    end
    checks++;
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      if ({result3, rv3, rej3} !== {e3.res, e3.vld, e3.rej}) begin
        errors++;
        $display("FAIL sb_tries3: got res=%b vld=%b rej=%b, want res=%b vld=%b rej=%b",
                 result3, rv3, rej3, e3.res, e3.vld, e3.rej);
      end
    end else if (rv3 !== 1'b0 || rej3 !== 1'b0) begin
      errors++;
      $display("FAIL sb_tries3_idle: got vld=%b rej=%b, want 0 0", rv3, rej3);
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic guess0(input logic [6:0] g, input exp_t e);
    user_number = g; guess_trigger = 1'b1; q0.push_back(e);
    tick();
    guess_trigger = 1'b0;
  endtask

  task automatic guess3(input logic [6:0] g, input exp_t e);
    num3 = g; trig3 = 1'b1; q3.push_back(e);
    tick();
    trig3 = 1'b0;
  endtask

  task automatic start0();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic start_3();
    start3 = 1'b1; tick(); start3 = 1'b0;
  endtask

  // Called at the negedge after the start edge; walks the model LFSR until a legal
  // candidate is latched. With poke set, a correct guess is driven on the latching
  // edge, which must be ignored because the core is still in GEN.
  task automatic wait_secret(input bit poke, output logic [6:0] s, output bit ok);
    logic [6:0] cand;
    ok = 1'b0; s = '0;
    for (int i = 0; i < 400; i++) begin
      cand = m_lfsr[6:0];
      if (cand != 7'd0 && cand <= 7'd99) begin
        if (poke) begin
          user_number = cand; guess_trigger = 1'b1; q0.push_back(mk(2'b00, 1'b0, 1'b0));
        end
        tick();
        guess_trigger = 1'b0;
        s = cand; ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, game_over, game_won, result, result_valid, guess_reject} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b over=%b won=%b res=%b vld=%b rej=%b, want all 0",
               busy, game_over, game_won, result, result_valid, guess_reject);
    end
    checks++;
    if (tries_used !== 3'd0 || actual !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: got tries=%0d secret=%0d, want 0 0", tries_used, actual);
    end
    checks++;
    if ({busy3, over3, won3, tries3} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dut3: got busy=%b over=%b won=%b tries=%0d, want 0", busy3, over3, won3, tries3);
    end
`ifdef UPDOWN_HINT_RANGE_EN
    checks++;
    if (lo_b !== 7'd1 || hi_b !== 7'd99) begin
      errors++;
      $display("FAIL reset_bounds: got lo=%0d hi=%0d, want 1 99", lo_b, hi_b);
    end
`endif
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_start();
    logic [6:0] s; bit ok;
    start0();
    checks++;
    if (busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: got busy=%b over=%b, want 1 0", busy, game_over);
    end
    wait_secret(1'b1, s, ok);
    first_secret = s;
    checks++;
    if (!ok || actual !== s) begin
      errors++;
      $display("FAIL start_secret: got %0d, want %0d (found=%0d)", actual, s, ok);
    end
    checks++;
    if (actual < 7'd1 || actual > 7'd99) begin
      errors++;
      $display("FAIL start_range: got %0d, want 1..99", actual);
    end
    checks++;
    if (tries_used !== 3'd0 || result !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_play: got tries=%0d res=%b busy=%b, want 0 00 1", tries_used, result, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s, g1, g2;
    s = actual;
    if (s == 7'd1)       begin g1 = 7'd3;  g2 = 7'd2;  end
    else if (s == 7'd99) begin g1 = 7'd97; g2 = 7'd98; end
    else                 begin g1 = s - 7'd1; g2 = s + 7'd1; end
    guess0(g1, mk(cmp(first_secret, g1), 1'b1, 1'b0));
    guess0(g2, mk(cmp(first_secret, g2), 1'b1, 1'b0));
    guess0(s,  mk(2'b11, 1'b1, 1'b0));
    checks++;
    if ({game_over, game_won, busy} !== 3'b110 || tries_used !== 3'd3 || result !== 2'b11) begin
      errors++;
      $display("FAIL win_state: got over=%b won=%b busy=%b tries=%0d res=%b, want 1 1 0 3 11",
               game_over, game_won, busy, tries_used, result);
    end
    guess0(7'd5, mk(2'b11, 1'b0, 1'b0));
    checks++;
    if (tries_used !== 3'd3 || game_won !== 1'b1) begin
      errors++;
      $display("FAIL win_hold: got tries=%0d won=%b, want 3 1", tries_used, game_won);
    end
  endtask

  task automatic test_reject();
    logic [6:0] s; bit ok;
    start0();
    wait_secret(1'b0, s, ok);
    checks++;
    if (!ok || actual !== s) begin
      errors++;
      $display("FAIL rej_secret: got %0d, want %0d", actual, s);
    end
    guess0(7'd0,   mk(2'b00, 1'b0, 1'b1));
    guess0(7'd100, mk(2'b00, 1'b0, 1'b1));
    guess0(7'd127, mk(2'b00, 1'b0, 1'b1));
    checks++;
    if (tries_used !== 3'd0 || result !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rej_tries: got tries=%0d res=%b busy=%b, want 0 00 1", tries_used, result, busy);
    end
`ifdef UPDOWN_HINT_RANGE_EN
    if (s >= 7'd2) begin
      guess0(s >> 1, mk(2'b01, 1'b1, 1'b0));
      checks++;
      if (lo_b !== (s >> 1) + 7'd1 || hi_b !== 7'd99) begin
        errors++;
        $display("FAIL hint_lo: got lo=%0d hi=%0d, want %0d 99", lo_b, hi_b, (s >> 1) + 7'd1);
      end
      guess0(s >> 1, mk(2'b01, 1'b0, 1'b1));
      checks++;
      if (tries_used !== 3'd1) begin
        errors++;
        $display("FAIL hint_rej_tries: got %0d, want 1", tries_used);
      end
    end
`endif
  endtask

  task automatic test_lose();
    logic [6:0] s, g; bit ok; logic [1:0] last;
    start_3();
    wait_secret(1'b0, s, ok);
    checks++;
    if (!ok || act3 !== s) begin
      errors++;
      $display("FAIL lose_secret: got %0d, want %0d", act3, s);
    end
    last = 2'b00;
    for (int i = 0; i < 3; i++) begin
      g = (s > 7'd3) ? 7'(i + 1) : 7'(99 - i);
      last = cmp(s, g);
      guess3(g, mk(last, 1'b1, 1'b0));
      if (i == 1) begin
        checks++;
        if (tries3 !== 2'd2 || busy3 !== 1'b1 || over3 !== 1'b0) begin
          errors++;
          $display("FAIL lose_mid: got tries=%0d busy=%b over=%b, want 2 1 0", tries3, busy3, over3);
        end
      end
    end
    checks++;
    if ({over3, won3, busy3} !== 3'b100 || tries3 !== 2'd3) begin
      errors++;
      $display("FAIL lose_state: got over=%b won=%b busy=%b tries=%0d, want 1 0 0 3", over3, won3, busy3, tries3);
    end
    guess3(s, mk(last, 1'b0, 1'b0));
    checks++;
    if (tries3 !== 2'd3 || won3 !== 1'b0 || over3 !== 1'b1) begin
      errors++;
      $display("FAIL lose_hold: got tries=%0d won=%b over=%b, want 3 0 1", tries3, won3, over3);
    end
  endtask

  task automatic test_start_with_guess();
    logic [6:0] s, g; bit ok;
    s = actual;
    g = (s == 7'd99) ? 7'd98 : 7'd99;
    guess0(g, mk(cmp(s, g), 1'b1, 1'b0));
    start = 1'b1; guess_trigger = 1'b1; user_number = s;
    q0.push_back(mk(2'b00, 1'b0, 1'b0));
    tick();
    start = 1'b0; guess_trigger = 1'b0;
    checks++;
    if (tries_used !== 3'd0 || result !== 2'b00 || busy !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: got tries=%0d res=%b busy=%b over=%b, want 0 00 1 0",
               tries_used, result, busy, game_over);
    end
    wait_secret(1'b0, s, ok);
    checks++;
    if (!ok || actual !== s) begin
      errors++;
      $display("FAIL restart_secret: got %0d, want %0d", actual, s);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s, g; bit ok;
    s = actual;
    for (int i = 0; i < 2; i++) begin
      g = (s > 7'd3) ? 7'(i + 1) : 7'(99 - i);
      guess0(g, mk(cmp(s, g), 1'b1, 1'b0));
    end
    checks++;
    if (tries_used !== 3'd2) begin
      errors++;
      $display("FAIL mid_tries: got %0d, want 2", tries_used);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, game_over, game_won, result, result_valid, guess_reject} !== 7'b0 ||
        tries_used !== 3'd0 || actual !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b over=%b won=%b res=%b tries=%0d secret=%0d, want all 0",
               busy, game_over, game_won, result, tries_used, actual);
    end
    reset = 1'b0;
    tick(); tick();
    start0();
    wait_secret(1'b0, s, ok);
    checks++;
    if (!ok || actual !== first_secret) begin
      errors++;
      $display("FAIL seed_repeat: got %0d, want %0d", actual, first_secret);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_back_to_back();
    test_reject();
    test_lose();
    test_start_with_guess();
    test_reset_mid();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
